// File: rtl/retire_map_table_if.sv
// Retire-side bus of the committed register map: retire ports in, map/free/recovery/perf out.
interface retire_map_table_if #(
  parameter int N_RET  = 2,
  parameter int N_AREG = 32,
  parameter int PTAG_W = 6,
  parameter int RCNT_W = 32
);
  localparam int AREG_W = $clog2(N_AREG);

  logic [N_RET-1:0]         ret_valid;
  logic [N_RET-1:0]         ret_wr;
  logic [N_RET*AREG_W-1:0]  ret_areg;
  logic [N_RET*PTAG_W-1:0]  ret_ptag;
  logic [N_RET*PTAG_W-1:0]  ret_told;
  logic [N_RET-1:0]         ret_mispred;
  logic [N_AREG*PTAG_W-1:0] map_out;
  logic [N_RET-1:0]         free_valid;
  logic [N_RET*PTAG_W-1:0]  free_tag;
  logic                     recover_valid;
  logic [RCNT_W-1:0]        retire_count;
  logic                     check_err;

  modport master (
    output ret_valid, ret_wr, ret_areg, ret_ptag, ret_told, ret_mispred,
    input  map_out, free_valid, free_tag, recover_valid, retire_count, check_err
  );

  modport slave (
    input  ret_valid, ret_wr, ret_areg, ret_ptag, ret_told, ret_mispred,
    output map_out, free_valid, free_tag, recover_valid, retire_count, check_err
  );
endinterface

// File: rtl/retire_map_table.sv
// Committed architectural register map behind ROB retire; releases displaced tags, flags recovery.
// Optional ARCH_MAP_CHECK_EN builds the ret_told consistency check driving a sticky check_err.
module retire_map_table #(
  parameter int N_RET  = 2,
  parameter int N_AREG = 32,
  parameter int PTAG_W = 6,
  parameter int RCNT_W = 32
) (
  input logic                clock,
  input logic                reset,
  retire_map_table_if.slave  rt
);
  localparam int AREG_W = $clog2(N_AREG);

  logic [PTAG_W-1:0]       map_q [N_AREG];
  logic [PTAG_W-1:0]       map_d [N_AREG];
  logic [N_RET-1:0]        free_valid_q, free_valid_d;
  logic [N_RET*PTAG_W-1:0] free_tag_q, free_tag_d;
  logic                    recover_q, recover_d;
  logic [RCNT_W-1:0]       count_q, count_d;
  logic [RCNT_W-1:0]       cnt_inc;
  logic                    killed;
  logic [AREG_W-1:0]       areg;
  logic [PTAG_W-1:0]       ptag;
  logic [PTAG_W-1:0]       old_tag;
`ifdef ARCH_MAP_CHECK_EN
  logic                    told_err;
  logic                    err_q;
`else
  logic                    unused_told;
`endif

  // Ports are walked oldest-first on a working copy so same-areg writes chain naturally.
  always_comb begin
    for (int i = 0; i < N_AREG; i++) map_d[i] = map_q[i];
    free_valid_d = '0;
    free_tag_d   = '0;
    recover_d    = 1'b0;
    cnt_inc      = '0;
    killed       = 1'b0;
    areg         = '0;
    ptag         = '0;
    old_tag      = '0;
`ifdef ARCH_MAP_CHECK_EN
    told_err     = 1'b0;
`endif
    for (int n = 0; n < N_RET; n++) begin
      areg = rt.ret_areg[n*AREG_W +: AREG_W];
      ptag = rt.ret_ptag[n*PTAG_W +: PTAG_W];
      if (rt.ret_valid[n] && !killed) begin
        cnt_inc = cnt_inc + RCNT_W'(1);
        if (rt.ret_wr[n]) begin
          free_valid_d[n] = 1'b1;
          if (areg == '0) begin
            free_tag_d[n*PTAG_W +: PTAG_W] = ptag;
          end else begin
            old_tag = map_d[areg];
            free_tag_d[n*PTAG_W +: PTAG_W] = old_tag;
            map_d[areg] = ptag;
`ifdef ARCH_MAP_CHECK_EN
            if (rt.ret_told[n*PTAG_W +: PTAG_W] != old_tag) told_err = 1'b1;
`endif
          end
        end
        // A mispredicting port still retires; everything younger this cycle is squashed.
        if (rt.ret_mispred[n]) begin
          recover_d = 1'b1;
          killed    = 1'b1;
        end
      end
    end
    count_d = count_q + cnt_inc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_AREG; i++) map_q[i] <= PTAG_W'(i + 1);
      free_valid_q <= '0;
      free_tag_q   <= '0;
      recover_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      for (int i = 0; i < N_AREG; i++) map_q[i] <= map_d[i];
      free_valid_q <= free_valid_d;
      free_tag_q   <= free_tag_d;
      recover_q    <= recover_d;
      count_q      <= count_d;
    end
  end

`ifdef ARCH_MAP_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else if (told_err) err_q <= 1'b1;
  end
  assign rt.check_err = err_q;
`else
  assign unused_told  = ^rt.ret_told;
  assign rt.check_err = 1'b0;
`endif

  for (genvar g = 0; g < N_AREG; g++) begin : g_map_out
    assign rt.map_out[g*PTAG_W +: PTAG_W] = map_q[g];
  end

  assign rt.free_valid    = free_valid_q;
  assign rt.free_tag      = free_tag_q;
  assign rt.recover_valid = recover_q;
  assign rt.retire_count  = count_q;
endmodule
